depthwise_conv_stream: RTL and testbench

- Streaming, sequential depthwise KxK convolution engine for the CNN datapath.
- Accepts one channel-packed pixel per handshake in raster order and buffers the last KERNEL_SIZE rows.
- For every full valid window it runs a KxK multiply-accumulate across all channels in parallel, then emits one packed, shifted, saturated output pixel.
- Per-channel weights are loaded through a write port.
- Sits between the pixel-stream front end and the pointwise stage.

---
 rtl/depthwise_conv_stream.sv | 221 ++++++++++++++++++++++
 tb/tb_depthwise_conv_stream.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depthwise_conv_stream.sv
// depthwise_conv_stream: streaming depthwise KxK convolution with "valid" padding.
// Pixels arrive in raster order into a K-row circular line buffer. Each full window
// triggers a K*K-cycle multiply-accumulate (all channels in parallel, one tap per cycle),
// then one shifted, saturated, channel-packed result is held until accepted.
// Optional feature macro: DWCONV_RELU_EN clamps negative channel results to zero.
module depthwise_conv_stream #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned IMG_WIDTH   = 16,
  parameter int unsigned IMG_HEIGHT  = 16,
  parameter int unsigned OUT_SHIFT   = 0,
  localparam int unsigned WAddrW     = $clog2(CHANNELS * KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [DATA_WIDTH*CHANNELS-1:0] in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DATA_WIDTH*CHANNELS-1:0] out_data_o,
  output logic                           frame_done_o,
  input  logic                           w_we_i,
  input  logic [WAddrW-1:0]              w_addr_i,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  output logic                           w_err_o
);

  localparam int unsigned K       = KERNEL_SIZE;
  localparam int unsigned KK      = K * K;
  localparam int unsigned NumW    = CHANNELS * KK;
  localparam int unsigned PixW    = DATA_WIDTH * CHANNELS;
  localparam int unsigned ProdW   = 2 * DATA_WIDTH;
  localparam int unsigned AccW    = ProdW + $clog2(KK);
  localparam int unsigned ColW    = $clog2(IMG_WIDTH);
  localparam int unsigned RowW    = $clog2(IMG_HEIGHT);
  localparam int unsigned KW      = $clog2(K);
  localparam int unsigned LbDepth = K * IMG_WIDTH;
  localparam int unsigned LbW     = $clog2(LbDepth);

  localparam logic signed [AccW-1:0] SatMax =
    {{(AccW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin =
    {{(AccW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

  state_e                  state_q, state_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [ColW-1:0]         col_q, col_d;
  logic [KW-1:0]           wrow_q, wrow_d;        // row mod K of the pixel being written
  logic [KW-1:0]           base_row_q, base_row_d;
  logic [ColW-1:0]         base_col_q, base_col_d;
  logic [KW-1:0]           tap_r_q, tap_r_d;
  logic [KW-1:0]           tap_c_q, tap_c_d;
  logic                    last_win_q, last_win_d;
  logic                    rdy_q;
  logic                    w_err_q;
  logic signed [AccW-1:0]  acc_q [CHANNELS];
  logic signed [AccW-1:0]  acc_d [CHANNELS];
  logic signed [DATA_WIDTH-1:0] wgt_q [NumW];
  logic [PixW-1:0]         lbuf_q [LbDepth];

  logic                    in_hs, w_ok, last_tap;
  logic [LbW-1:0]          wr_idx, rd_idx;
  logic [KW:0]             rd_row_sum;
  logic [KW-1:0]           rd_row;
  logic [PixW-1:0]         rd_pix;
  logic signed [ProdW-1:0] prod [CHANNELS];
  logic signed [AccW-1:0]  sh;
  logic [DATA_WIDTH-1:0]   res;

  assign in_ready_o   = rdy_q && (state_q == StIdle);
  assign in_hs        = in_valid_i && in_ready_o;
  assign out_valid_o  = (state_q == StOutput);
  assign frame_done_o = (state_q == StOutput) && out_ready_i && last_win_q;
  assign w_err_o      = w_err_q;
  assign w_ok         = w_we_i && (state_q == StIdle) && !in_hs && (32'(w_addr_i) < NumW);
  assign last_tap     = (tap_r_q == KW'(K - 1)) && (tap_c_q == KW'(K - 1));

  assign wr_idx     = LbW'(32'(wrow_q) * IMG_WIDTH + 32'(col_q));
  assign rd_row_sum = {1'b0, base_row_q} + {1'b0, tap_r_q};
  assign rd_row     = (rd_row_sum >= (KW + 1)'(K)) ? KW'(rd_row_sum - (KW + 1)'(K))
                                                   : rd_row_sum[KW-1:0];
  assign rd_idx     = LbW'(32'(rd_row) * IMG_WIDTH + 32'(base_col_q) + 32'(tap_c_q));
  assign rd_pix     = lbuf_q[rd_idx];

  // Per-channel product of the current tap pixel and its weight.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      prod[c] = ProdW'($signed(rd_pix[c*DATA_WIDTH +: DATA_WIDTH])) *
                ProdW'(wgt_q[WAddrW'(c * KK + 32'(tap_r_q) * K + 32'(tap_c_q))]);
    end
  end

  // Next-state logic: pixel counters, window capture, tap sequencing, accumulation.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    wrow_d     = wrow_q;
    base_row_d = base_row_q;
    base_col_d = base_col_q;
    tap_r_d    = tap_r_q;
    tap_c_d    = tap_c_q;
    last_win_d = last_win_q;
    for (int c = 0; c < CHANNELS; c++) acc_d[c] = acc_q[c];

    unique case (state_q)
      StIdle: begin
        if (in_hs) begin
          if (col_q == ColW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == RowW'(IMG_HEIGHT - 1)) begin
              row_d  = '0;
              wrow_d = '0;
            end else begin
              row_d  = row_q + 1'b1;
              wrow_d = (wrow_q == KW'(K - 1)) ? '0 : wrow_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
          if (row_q >= RowW'(K - 1) && col_q >= ColW'(K - 1)) begin
            state_d    = StCompute;
            // Oldest window row sits one past the write row in the circular buffer.
            base_row_d = (wrow_q == KW'(K - 1)) ? '0 : wrow_q + 1'b1;
            base_col_d = col_q - ColW'(K - 1);
            tap_r_d    = '0;
            tap_c_d    = '0;
            last_win_d = (row_q == RowW'(IMG_HEIGHT - 1)) && (col_q == ColW'(IMG_WIDTH - 1));
            for (int c = 0; c < CHANNELS; c++) acc_d[c] = '0;
          end
        end
      end
      StCompute: begin
        for (int c = 0; c < CHANNELS; c++) acc_d[c] = acc_q[c] + AccW'(prod[c]);
        if (last_tap) begin
          state_d = StOutput;
        end else if (tap_c_q == KW'(K - 1)) begin
          tap_c_d = '0;
          tap_r_d = tap_r_q + 1'b1;
        end else begin
          tap_c_d = tap_c_q + 1'b1;
        end
      end
      StOutput: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output formatting: arithmetic shift, saturate, optional clamp, pack channels.
  always_comb begin
    out_data_o = '0;
    sh         = '0;
    res        = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sh = acc_q[c] >>> OUT_SHIFT;
      if (sh > SatMax) begin
        res = SatMax[DATA_WIDTH-1:0];
      end else if (sh < SatMin) begin
        res = SatMin[DATA_WIDTH-1:0];
      end else begin
        res = sh[DATA_WIDTH-1:0];
      end
`ifdef DWCONV_RELU_EN
      if (res[DATA_WIDTH-1]) res = '0;
`endif
      out_data_o[c*DATA_WIDTH +: DATA_WIDTH] = res;
    end
  end

  // Control and accumulator state; rdy_q holds in_ready low until the first edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      wrow_q     <= '0;
      base_row_q <= '0;
      base_col_q <= '0;
      tap_r_q    <= '0;
      tap_c_q    <= '0;
      last_win_q <= 1'b0;
      rdy_q      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wrow_q     <= wrow_d;
      base_row_q <= base_row_d;
      base_col_q <= base_col_d;
      tap_r_q    <= tap_r_d;
      tap_c_q    <= tap_c_d;
      last_win_q <= last_win_d;
      rdy_q      <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
    end
  end

  // Weight store: writes land only in idle without a same-cycle pixel; others flag w_err.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumW; i++) wgt_q[i] <= '0;
      w_err_q <= 1'b0;
    end else begin
      w_err_q <= w_we_i && !w_ok;
      if (w_ok) wgt_q[w_addr_i] <= w_data_i;
    end
  end

  // Line buffer: contents need no reset.
  always_ff @(posedge clk_i) begin
    if (in_hs) lbuf_q[wr_idx] <= in_data_i;
  end

endmodule

// File: tb/tb_depthwise_conv_stream.sv
// Bench for depthwise_conv_stream: K=3, 4x4 image, 2 channels. Two instances share all
// inputs; one uses OUT_SHIFT=0 and the other OUT_SHIFT=7. Expected results are pushed to
// a scoreboard as each triggering pixel is driven and popped on output handshakes.
module tb_depthwise_conv_stream;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int CH = 2;
  localparam int W  = 4;
  localparam int H  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        w_we = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        in_ready0, out_valid0, frame_done0, w_err0;
  logic        in_ready1, out_valid1, frame_done1, w_err1;
  logic [15:0] out_data0, out_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_cnt = 0;
  int fd_cnt = 0;
  int last_hs_cyc = 0;
  int img [H][W][CH];
  int wt [CH][K*K];
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  bit          exp_fd [$];
  logic [15:0] last_out0 = '0;
  logic [15:0] last_out1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  depthwise_conv_stream #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .CHANNELS(CH), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .OUT_SHIFT(0)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_data_o(out_data0), .frame_done_o(frame_done0), .w_we_i(w_we), .w_addr_i(w_addr),
    .w_data_i(w_data), .w_err_o(w_err0)
  );

  depthwise_conv_stream #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .CHANNELS(CH), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .OUT_SHIFT(7)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_data_i(in_data), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .out_data_o(out_data1), .frame_done_o(frame_done1), .w_we_i(w_we), .w_addr_i(w_addr),
    .w_data_i(w_data), .w_err_o(w_err1)
  );

  // Reference: valid-padding window at (r0,c0), shift, saturate, optional clamp.
  function automatic logic [15:0] model_win(input int r0, input int c0, input int shift);
    logic [15:0] r;
    r = '0;
    for (int ch = 0; ch < CH; ch++) begin
      int acc;
      acc = 0;
      for (int tr = 0; tr < K; tr++)
        for (int tc = 0; tc < K; tc++)
          acc += img[r0+tr][c0+tc][ch] * wt[ch][tr*K+tc];
      acc = acc >>> shift;
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
`ifdef DWCONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      r[ch*8 +: 8] = 8'(acc);
    end
    return r;
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    logic [15:0] e0, e1;
    bit efd;
    if (rst_n) begin
      if (frame_done0) fd_cnt++;
      if (out_valid0 && out_ready) begin
        out_cnt++;
        last_out0 = out_data0;
        last_out1 = out_data1;
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h want none", out_data0);
        end else begin
          e0  = exp0.pop_front();
          e1  = exp1.pop_front();
          efd = exp_fd.pop_front();
          if (out_data0 !== e0) begin
            errors++;
            $display("FAIL out_data_shift0 got=%h want=%h", out_data0, e0);
          end
          checks++;
          if (out_data1 !== e1) begin
            errors++;
            $display("FAIL out_data_shift7 got=%h want=%h", out_data1, e1);
          end
          checks++;
          if ({out_valid1, frame_done0, frame_done1} !== {1'b1, efd, efd}) begin
            errors++;
            $display("FAIL frame_done got=%b%b want=%b", frame_done0, frame_done1, efd);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1);
  end

  task automatic set_img(input bit ramp, input int a, input int b);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c][0] = ramp ? r*W + c : a;
        img[r][c][1] = ramp ? r*W + c + 20 : b;
      end
  endtask

  task automatic push_pixel(input int r, input int c);
    int n;
    n = 0;
    in_data  = {8'(img[r][c][1]), 8'(img[r][c][0])};
    in_valid = 1'b1;
    while (!in_ready0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout r=%0d c=%0d got=0 want=1", r, c);
    end
    last_hs_cyc = cyc;
    if (r >= K-1 && c >= K-1) begin
      exp0.push_back(model_win(r-K+1, c-K+1, 0));
      exp1.push_back(model_win(r-K+1, c-K+1, 7));
      exp_fd.push_back(r == H-1 && c == W-1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < H*W; i++) push_pixel(i / W, i % W);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp0.size() != 0 || !in_ready0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp0.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp0.size());
    end
  endtask

  task automatic write_w(input int addr, input int val, input bit exp_err);
    w_we = 1'b1; w_addr = 5'(addr); w_data = 8'(val);
    @(posedge clk); #1;
    w_we = 1'b0;
    checks++;
    if ({w_err0, w_err1} !== {exp_err, exp_err}) begin
      errors++;
      $display("FAIL w_err addr=%0d got=%b want=%b", addr, w_err0, exp_err);
    end
    if (!exp_err) wt[addr / (K*K)][addr % (K*K)] = val;
    @(posedge clk); #1;
    checks++;
    if (w_err0 !== 1'b0) begin
      errors++;
      $display("FAIL w_err_pulse addr=%0d got=%b want=0", addr, w_err0);
    end
  endtask

  task automatic load_weights(input int v0, input int v1);
    for (int a = 0; a < CH*K*K; a++) write_w(a, (a < K*K) ? v0 : v1, 1'b0);
  endtask

  task automatic check_last(input string name, input logic [15:0] w0, input logic [15:0] w1);
    checks++;
    if (last_out0 !== w0 || last_out1 !== w1) begin
      errors++;
      $display("FAIL %s got=%h/%h want=%h/%h", name, last_out0, last_out1, w0, w1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready0, out_valid0, frame_done0, w_err0, in_ready1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {in_ready0, out_valid0, frame_done0, w_err0, in_ready1});
    end
    checks++;
    if (out_data0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0000", out_data0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=1", in_ready0);
    end
    // Cleared weights give all-zero outputs.
    set_img(1'b0, 5, -7);
    send_frame();
    wait_drain();
    check_last("zero_weights", 16'h0000, 16'h0000);
  endtask

  task automatic test_identity();
    int o0, f0, n, lat;
    load_weights(1, 1);
    set_img(1'b0, 1, 1);
    o0 = out_cnt;
    f0 = fd_cnt;
    for (int i = 0; i < H*W; i++) begin
      push_pixel(i / W, i % W);
      if (i == 10) begin
        n = 0;
        while (!out_valid0 && n < 50) begin
          @(negedge clk);
          n++;
        end
        lat = cyc - last_hs_cyc;
        checks++;
        if (lat != K*K + 1) begin
          errors++;
          $display("FAIL latency got=%0d want=%0d", lat, K*K + 1);
        end
      end
    end
    wait_drain();
    check_last("identity_value", 16'h0909, 16'h0000);
    checks++;
    if (out_cnt - o0 != 4 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL identity_counts got=%0d/%0d want=4/1", out_cnt - o0, fd_cnt - f0);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] neg0, neg1;
`ifdef DWCONV_RELU_EN
    neg0 = 16'h0000; neg1 = 16'h0000;
`else
    neg0 = 16'h8080; neg1 = 16'h8080;
`endif
    load_weights(127, 127);
    set_img(1'b0, 127, 127);
    send_frame();
    wait_drain();
    check_last("sat_pos", 16'h7F7F, 16'h7F7F);
    set_img(1'b0, -128, -128);
    send_frame();
    wait_drain();
    check_last("sat_neg", neg0, neg1);
    load_weights(64, 64);
    set_img(1'b0, 2, 2);
    send_frame();
    wait_drain();
    check_last("shift7", 16'h7F7F, 16'h0909);
  endtask

  task automatic test_channels();
    load_weights(0, 0);
    write_w(4, 1, 1'b0);
    write_w(9, 1, 1'b0);
    set_img(1'b1, 0, 0);
    send_frame();
    wait_drain();
    // Last window origin (1,1): ch0 = pixel(2,2)=10, ch1 = pixel(1,1)=5+20.
    check_last("channels", {8'd25, 8'd10}, 16'h0000);
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] want;
    load_weights(1, 2);
    set_img(1'b1, 0, 0);
    out_ready = 1'b0;
    for (int i = 0; i <= 10; i++) push_pixel(i / W, i % W);
    in_data  = {8'(img[2][3][1]), 8'(img[2][3][0])};
    in_valid = 1'b1;
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    want = model_win(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_data0 !== want) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%b%b/%h want=10/%h", i, out_valid0, in_ready0,
                 out_data0, want);
      end
    end
    out_ready = 1'b1;
    for (int i = 11; i < H*W; i++) push_pixel(i / W, i % W);
    wait_drain();
  endtask

  task automatic test_weight_rules();
    int n;
    load_weights(1, 1);
    set_img(1'b0, 1, 1);
    for (int i = 0; i <= 10; i++) push_pixel(i / W, i % W);
    write_w(0, 5, 1'b1);  // engine is computing: dropped
    n = 0;
    while (!in_ready0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    write_w(18, 7, 1'b1);  // out of range
    write_w(4, 3, 1'b0);   // idle: applies to next window
    for (int i = 11; i < H*W; i++) push_pixel(i / W, i % W);
    wait_drain();
    check_last("weight_update", {8'd9, 8'd11}, 16'h0000);
  endtask

  task automatic test_back_to_back();
    int o0, f0;
    load_weights(1, -1);
    set_img(1'b1, 0, 0);
    o0 = out_cnt;
    f0 = fd_cnt;
    send_frame();
    set_img(1'b0, 3, -2);
    send_frame();
    wait_drain();
    checks++;
    if (out_cnt - o0 != 8 || fd_cnt - f0 != 2) begin
      errors++;
      $display("FAIL b2b_counts got=%0d/%0d want=8/2", out_cnt - o0, fd_cnt - f0);
    end
  endtask

  task automatic test_reset_midframe();
    int o0;
    load_weights(1, -1);
    set_img(1'b1, 0, 0);
    for (int i = 0; i < 7; i++) push_pixel(i / W, i % W);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset got=%b%b want=00", out_valid0, in_ready0);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid0, in_ready0, w_err0} !== 3'b000 || out_data0 !== 16'h0) begin
      errors++;
      $display("FAIL midreset_hold got=%b/%h want=000/0000",
               {out_valid0, in_ready0, w_err0}, out_data0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < K*K; t++) wt[c][t] = 0;
    @(posedge clk); #1;
    load_weights(1, -1);
    o0 = out_cnt;
    send_frame();
    wait_drain();
    checks++;
    if (out_cnt - o0 != 4) begin
      errors++;
      $display("FAIL midreset_count got=%0d want=4", out_cnt - o0);
    end
  endtask

  task automatic test_relu();
    logic [15:0] w0, w1;
`ifdef DWCONV_RELU_EN
    w0 = 16'h0000; w1 = 16'h0000;
`else
    w0 = 16'hF7F7; w1 = 16'hFFFF;
`endif
    load_weights(-1, -1);
    set_img(1'b0, 1, 1);
    send_frame();
    wait_drain();
    check_last("negative_result", w0, w1);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_channels();
    test_backpressure();
    test_weight_rules();
    test_back_to_back();
    test_reset_midframe();
    test_relu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
